// File: rtl/key_pkg.sv
// Shared constants, FSM encoding and scan-code decode for the PS/2 key event sequencer.
package key_pkg;

  localparam logic [7:0] CodeA      = 8'h1C;
  localparam logic [7:0] CodeB      = 8'h32;
  localparam logic [7:0] CodeC      = 8'h21;
  localparam logic [7:0] CodeD      = 8'h23;
  localparam logic [7:0] CodeUp     = 8'h75;
  localparam logic [7:0] CodeDown   = 8'h72;
  localparam logic [7:0] CodeRight  = 8'h74;
  localparam logic [7:0] CodeLeft   = 8'h6B;
  localparam logic [7:0] CodePfxExt = 8'hE0;
  localparam logic [7:0] CodePfxBrk = 8'hF0;

  localparam logic [2:0] KeyA     = 3'd0;
  localparam logic [2:0] KeyB     = 3'd1;
  localparam logic [2:0] KeyC     = 3'd2;
  localparam logic [2:0] KeyD     = 3'd3;
  localparam logic [2:0] KeyUp    = 3'd4;
  localparam logic [2:0] KeyDown  = 3'd5;
  localparam logic [2:0] KeyRight = 3'd6;
  localparam logic [2:0] KeyLeft  = 3'd7;

  localparam int unsigned EvValidBit = 7;
  localparam int unsigned EvMakeBit  = 6;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } pfx_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Letters only exist without E0; arrows accept both so keypad arrows also count.
  function automatic key_hit_t decode_key(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = KeyA;
    case (code)
      CodeA:     begin r.idx = KeyA;     r.hit = ~ext; end
      CodeB:     begin r.idx = KeyB;     r.hit = ~ext; end
      CodeC:     begin r.idx = KeyC;     r.hit = ~ext; end
      CodeD:     begin r.idx = KeyD;     r.hit = ~ext; end
      CodeUp:    r.idx = KeyUp;
      CodeDown:  r.idx = KeyDown;
      CodeRight: r.idx = KeyRight;
      CodeLeft:  r.idx = KeyLeft;
      default:   r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] make_event(input logic make, input logic [2:0] idx);
    logic [7:0] ev;
    ev = 8'h00;
    ev[EvValidBit] = 1'b1;
    ev[EvMakeBit]  = make;
    ev[2:0]        = idx;
    return ev;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous 8-bit event FIFO; pointers carry an extra wrap bit to tell full from empty.
module key_event_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]     mem_q [Depth];
  logic           do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// PS/2 set-2 prefix tracker and key decoder feeding the event FIFO and the held-key vector.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PREFIX_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] keycodeout,
  input  logic       ev_read,
  output logic [7:0] ev_data,
  output logic       ev_pending,
  output logic [7:0] key_held,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int unsigned TimerW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(PREFIX_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);

  pfx_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        held_q, held_d;
  logic              overflow_q, overflow_d;

  logic       is_ev, ev_make, ev_ext;
  key_hit_t   hit;
  logic       push;
  logic [7:0] ev_word;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       drop;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    is_ev   = 1'b0;
    ev_make = (state_q == StIdle) || (state_q == StExt);
    ev_ext  = (state_q == StExt) || (state_q == StExtBrk);
    if (rx_done_tick) begin
      timer_d = '0;
      if (keycodeout == CodePfxExt) begin
        state_d = StExt;
      end else if (keycodeout == CodePfxBrk) begin
        state_d = (state_q == StExt) ? StExtBrk : StBrk;
      end else begin
        is_ev   = 1'b1;
        state_d = StIdle;
      end
    end else if (state_q != StIdle) begin
      if (timer_q == TimerLast) begin
        state_d = StIdle;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TimerOne;
      end
    end
  end

  // Held vector is ordered with key index 0 in bit 7, so key k lives at bit ~k.
  always_comb begin
    held_d  = held_q;
    push    = 1'b0;
    hit     = decode_key(keycodeout, ev_ext);
    ev_word = make_event(ev_make, hit.idx);
    if (is_ev && hit.hit) begin
      if (ev_make && !held_q[~hit.idx]) begin
        held_d[~hit.idx] = 1'b1;
        push             = 1'b1;
      end else if (!ev_make && held_q[~hit.idx]) begin
        held_d[~hit.idx] = 1'b0;
        push             = 1'b1;
      end
    end
  end

  always_comb begin
    drop       = push && fifo_full && !ev_read;
    overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      held_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  key_event_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (push),
    .data_i (ev_word),
    .pop_i  (ev_read),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  assign ev_data    = fifo_empty ? 8'h00 : fifo_head;
  assign ev_pending = !fifo_empty;
  assign key_held   = held_q;
  assign overflow   = overflow_q;

endmodule
